// File: rtl/mul_div_issue_queue.sv
// In-order issue queue for the mul/div unit: holds HI/LO + rs/rt operand pairs,
// snoops writeback broadcasts and issues the head pair once all four operands are present.
module mul_div_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 8,
  parameter int NUM_WB = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [OP_W-1:0]           enq_op,
  input  logic                      enq_rf_we1,
  input  logic                      enq_rf_we2,
  input  logic [PREG_W-1:0]         enq_phy_dest1,
  input  logic [PREG_W-1:0]         enq_phy_dest2,
  input  logic [ROB_W-1:0]          enq_rob1,
  input  logic [ROB_W-1:0]          enq_rob2,
  input  logic [4*PREG_W-1:0]       enq_src_tag,
  input  logic [3:0]                enq_src_rdy,
  input  logic [4*32-1:0]           enq_src_value,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]  wb_tag,
  input  logic [NUM_WB*32-1:0]      wb_value,
  output logic                      issue_valid,
  input  logic                      mul_div_allowin,
  output logic [OP_W-1:0]           issue_op,
  output logic                      issue_rf_we1,
  output logic                      issue_rf_we2,
  output logic [PREG_W-1:0]         issue_phy_dest1,
  output logic [PREG_W-1:0]         issue_phy_dest2,
  output logic [ROB_W-1:0]          issue_rob1,
  output logic [ROB_W-1:0]          issue_rob2,
  output logic [31:0]               issue_hi,
  output logic [31:0]               issue_lo,
  output logic [31:0]               issue_src1,
  output logic [31:0]               issue_src2,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W:0]     head;
  logic [PTR_W:0]     tail;
  logic [PTR_W-1:0]   head_idx;
  logic [PTR_W-1:0]   tail_idx;
  logic               full;
  logic               enq_fire;
  logic               deq_fire;

  logic               valid_q [DEPTH];
  logic [OP_W-1:0]    op_q    [DEPTH];
  logic               we1_q   [DEPTH];
  logic               we2_q   [DEPTH];
  logic [PREG_W-1:0]  dest1_q [DEPTH];
  logic [PREG_W-1:0]  dest2_q [DEPTH];
  logic [ROB_W-1:0]   rob1_q  [DEPTH];
  logic [ROB_W-1:0]   rob2_q  [DEPTH];
  logic [PREG_W-1:0]  tag_q   [DEPTH][4];
  logic [3:0]         rdy_q   [DEPTH];
  logic [31:0]        val_q   [DEPTH][4];

  logic [32:0]        wake     [DEPTH][4];
  logic [32:0]        enq_wake [4];

  // Returns {hit, value}; scanning from the top port down lets the lowest index win.
  function automatic logic [32:0] snoop(input logic [PREG_W-1:0] t);
    logic [32:0] r;
    r = '0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (wb_valid[p] && (wb_tag[p*PREG_W +: PREG_W] == t)) begin
        r = {1'b1, wb_value[p*32 +: 32]};
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = 0; k < 4; k++) begin
        wake[e][k] = snoop(tag_q[e][k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      enq_wake[k] = snoop(enq_src_tag[k*PREG_W +: PREG_W]);
    end
  end

  assign head_idx    = head[PTR_W-1:0];
  assign tail_idx    = tail[PTR_W-1:0];
  assign full        = (count == CNT_W'(DEPTH));
  assign enq_ready   = !full;
  assign enq_fire    = enq_valid && enq_ready && !flush;
  assign issue_valid = valid_q[head_idx] && (&rdy_q[head_idx]) && !flush;
  assign deq_fire    = issue_valid && mul_div_allowin;

  assign issue_op        = op_q[head_idx];
  assign issue_rf_we1    = we1_q[head_idx];
  assign issue_rf_we2    = we2_q[head_idx];
  assign issue_phy_dest1 = dest1_q[head_idx];
  assign issue_phy_dest2 = dest2_q[head_idx];
  assign issue_rob1      = rob1_q[head_idx];
  assign issue_rob2      = rob2_q[head_idx];
  assign issue_hi        = val_q[head_idx][0];
  assign issue_lo        = val_q[head_idx][1];
  assign issue_src1      = val_q[head_idx][2];
  assign issue_src2      = val_q[head_idx][3];

  // Payload is cleared on reset too, so the head-driven issue outputs read zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        valid_q[e] <= 1'b0;
        op_q[e]    <= '0;
        we1_q[e]   <= 1'b0;
        we2_q[e]   <= 1'b0;
        dest1_q[e] <= '0;
        dest2_q[e] <= '0;
        rob1_q[e]  <= '0;
        rob2_q[e]  <= '0;
        rdy_q[e]   <= '0;
        for (int k = 0; k < 4; k++) begin
          tag_q[e][k] <= '0;
          val_q[e][k] <= '0;
        end
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        valid_q[e] <= 1'b0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int k = 0; k < 4; k++) begin
          if (valid_q[e] && !rdy_q[e][k] && wake[e][k][32]) begin
            rdy_q[e][k] <= 1'b1;
            val_q[e][k] <= wake[e][k][31:0];
          end
        end
      end
      if (enq_fire) begin
        valid_q[tail_idx] <= 1'b1;
        op_q[tail_idx]    <= enq_op;
        we1_q[tail_idx]   <= enq_rf_we1;
        we2_q[tail_idx]   <= enq_rf_we2;
        dest1_q[tail_idx] <= enq_phy_dest1;
        dest2_q[tail_idx] <= enq_phy_dest2;
        rob1_q[tail_idx]  <= enq_rob1;
        rob2_q[tail_idx]  <= enq_rob2;
        for (int k = 0; k < 4; k++) begin
          tag_q[tail_idx][k] <= enq_src_tag[k*PREG_W +: PREG_W];
          if (enq_src_rdy[k]) begin
            rdy_q[tail_idx][k] <= 1'b1;
            val_q[tail_idx][k] <= enq_src_value[k*32 +: 32];
          end else begin
            rdy_q[tail_idx][k] <= enq_wake[k][32];
            val_q[tail_idx][k] <= enq_wake[k][31:0];
          end
        end
        tail <= tail + 1'b1;
      end
      if (deq_fire) begin
        valid_q[head_idx] <= 1'b0;
        head              <= head + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_issue_queue.sv
// Directed bench for mul_div_issue_queue: hand-computed expectations checked with immediate assertions.
module tb_mul_div_issue_queue;

  localparam logic [7:0] OP_MULT = 8'h01;
  localparam logic [7:0] OP_DIV  = 8'h02;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush;
  logic         enq_valid;
  logic         enq_ready;
  logic [7:0]   enq_op;
  logic         enq_rf_we1, enq_rf_we2;
  logic [5:0]   enq_phy_dest1, enq_phy_dest2;
  logic [3:0]   enq_rob1, enq_rob2;
  logic [23:0]  enq_src_tag;
  logic [3:0]   enq_src_rdy;
  logic [127:0] enq_src_value;
  logic [1:0]   wb_valid;
  logic [11:0]  wb_tag;
  logic [63:0]  wb_value;
  logic         issue_valid;
  logic         mul_div_allowin;
  logic [7:0]   issue_op;
  logic         issue_rf_we1, issue_rf_we2;
  logic [5:0]   issue_phy_dest1, issue_phy_dest2;
  logic [3:0]   issue_rob1, issue_rob2;
  logic [31:0]  issue_hi, issue_lo, issue_src1, issue_src2;
  logic [2:0]   count;

  int tests = 0;
  int failures = 0;

  mul_div_issue_queue dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_op(enq_op),
    .enq_rf_we1(enq_rf_we1), .enq_rf_we2(enq_rf_we2),
    .enq_phy_dest1(enq_phy_dest1), .enq_phy_dest2(enq_phy_dest2),
    .enq_rob1(enq_rob1), .enq_rob2(enq_rob2),
    .enq_src_tag(enq_src_tag), .enq_src_rdy(enq_src_rdy), .enq_src_value(enq_src_value),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .issue_valid(issue_valid), .mul_div_allowin(mul_div_allowin),
    .issue_op(issue_op), .issue_rf_we1(issue_rf_we1), .issue_rf_we2(issue_rf_we2),
    .issue_phy_dest1(issue_phy_dest1), .issue_phy_dest2(issue_phy_dest2),
    .issue_rob1(issue_rob1), .issue_rob2(issue_rob2),
    .issue_hi(issue_hi), .issue_lo(issue_lo), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Offers one pair; slots 0..2 use tags 20..22, slot 3 uses t3; hi=lo=0.
  task automatic applyStimulus(input logic [3:0] rob, input logic [7:0] op, input logic [3:0] rdy,
                               input logic [31:0] s1, input logic [31:0] s2, input logic [5:0] t3);
    enq_valid     = 1'b1;
    enq_op        = op;
    enq_rf_we1    = 1'b1;
    enq_rf_we2    = 1'b1;
    enq_phy_dest1 = {2'b00, rob};
    enq_phy_dest2 = {2'b01, rob};
    enq_rob1      = rob;
    enq_rob2      = rob + 4'd1;
    enq_src_tag   = {t3, 6'd22, 6'd21, 6'd20};
    enq_src_rdy   = rdy;
    enq_src_value = {s2, s1, 32'h0, 32'h0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_op = '0;
    enq_rf_we1 = 1'b0; enq_rf_we2 = 1'b0; enq_phy_dest1 = '0; enq_phy_dest2 = '0;
    enq_rob1 = '0; enq_rob2 = '0; enq_src_tag = '0; enq_src_rdy = '0; enq_src_value = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0; mul_div_allowin = 1'b0;

    #3;
    checkOutput("reset_enq_ready", 32'(enq_ready), 32'd1);
    checkOutput("reset_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_issue_src1", issue_src1, 32'd0);
    #9 resetn = 1'b1;
    tick();

    // All-ready MULT issues the cycle after enqueue and drains the next.
    mul_div_allowin = 1'b1;
    applyStimulus(4'd0, OP_MULT, 4'hF, 32'hFFFF_FFFE, 32'd3, 6'd23);
    checkOutput("mult_empty_no_issue", 32'(issue_valid), 32'd0);
    tick();
    enq_valid = 1'b0;
    checkOutput("mult_issue_valid", 32'(issue_valid), 32'd1);
    checkOutput("mult_src1", issue_src1, 32'hFFFF_FFFE);
    checkOutput("mult_src2", issue_src2, 32'd3);
    checkOutput("mult_hi", issue_hi, 32'd0);
    checkOutput("mult_op", 32'(issue_op), 32'(OP_MULT));
    checkOutput("mult_count1", 32'(count), 32'd1);
    tick();
    checkOutput("mult_count0", 32'(count), 32'd0);
    checkOutput("mult_drained", 32'(issue_valid), 32'd0);

    // DIV with rt pending on tag 9, woken by port 1 two cycles later; port 0 hits a ready slot.
    applyStimulus(4'd1, OP_DIV, 4'b0111, 32'd100, 32'hBAD0_BAD0, 6'd9);
    tick();
    enq_valid = 1'b0;
    checkOutput("div_wait0", 32'(issue_valid), 32'd0);
    checkOutput("div_count", 32'(count), 32'd1);
    tick();
    checkOutput("div_wait1", 32'(issue_valid), 32'd0);
    wb_valid = 2'b11; wb_tag = {6'd9, 6'd22}; wb_value = {32'd7, 32'hDEAD_BEEF};
    #1;
    checkOutput("div_no_comb_path", 32'(issue_valid), 32'd0);
    tick();
    wb_valid = 2'b00;
    checkOutput("div_woken", 32'(issue_valid), 32'd1);
    checkOutput("div_src2", issue_src2, 32'd7);
    checkOutput("div_src1_kept", issue_src1, 32'd100);
    tick();

    // Enqueue-cycle snoop with both ports matching: port 0 must win.
    applyStimulus(4'd2, OP_DIV, 4'b0111, 32'd50, 32'h0, 6'd9);
    wb_valid = 2'b11; wb_tag = {6'd9, 6'd9}; wb_value = {32'h77, 32'h55};
    tick();
    enq_valid = 1'b0; wb_valid = 2'b00;
    checkOutput("snoop_issue_valid", 32'(issue_valid), 32'd1);
    checkOutput("snoop_low_port", issue_src2, 32'h55);
    tick();
    checkOutput("snoop_drained", 32'(count), 32'd0);

    // Fill with the unit stalled: four accepted, fifth held until a dequeue frees space.
    mul_div_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'(i), OP_MULT, 4'hF, 32'(i), 32'(i + 10), 6'd23);
      checkOutput("fill_enq_ready", 32'(enq_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_ready", 32'(enq_ready), 32'd0);
    checkOutput("full_head_rob", 32'(issue_rob1), 32'd0);
    mul_div_allowin = 1'b1;
    tick();
    mul_div_allowin = 1'b0;
    checkOutput("full_deq_count", 32'(count), 32'd3);
    checkOutput("full_deq_ready", 32'(enq_ready), 32'd1);
    tick();
    enq_valid = 1'b0;
    checkOutput("fifth_accepted", 32'(count), 32'd4);
    mul_div_allowin = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checkOutput("drain_rob", 32'(issue_rob1), 32'(i));
      tick();
    end
    checkOutput("drain_count", 32'(count), 32'd0);

    // Incomplete head blocks a complete younger entry.
    applyStimulus(4'd5, OP_DIV, 4'b0111, 32'd1, 32'd0, 6'd12);
    tick();
    applyStimulus(4'd6, OP_MULT, 4'hF, 32'd2, 32'd3, 6'd23);
    tick();
    enq_valid = 1'b0;
    checkOutput("block_no_issue0", 32'(issue_valid), 32'd0);
    checkOutput("block_count", 32'(count), 32'd2);
    tick();
    checkOutput("block_no_issue1", 32'(issue_valid), 32'd0);
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd12}; wb_value = {32'd0, 32'd1};
    tick();
    wb_valid = 2'b00;
    checkOutput("block_head_rob", 32'(issue_rob1), 32'd5);
    checkOutput("block_head_valid", 32'(issue_valid), 32'd1);
    tick();
    checkOutput("block_second_rob", 32'(issue_rob1), 32'd6);
    checkOutput("block_second_valid", 32'(issue_valid), 32'd1);
    tick();
    checkOutput("block_count0", 32'(count), 32'd0);

    // Ten enqueue/dequeue pairs walk the pointers across the wrap.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'(i), OP_MULT, 4'hF, 32'(i), 32'(i), 6'd23);
      tick();
      enq_valid = 1'b0;
      checkOutput("wrap_rob", 32'(issue_rob1), 32'(i));
      tick();
    end
    checkOutput("wrap_count", 32'(count), 32'd0);

    // Flush with three entries and a pair offered in the same cycle.
    mul_div_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'(i), OP_MULT, 4'hF, 32'(i), 32'(i), 6'd23);
      tick();
    end
    applyStimulus(4'd7, OP_MULT, 4'hF, 32'd7, 32'd7, 6'd23);
    flush = 1'b1;
    #1;
    checkOutput("flush_gates_issue", 32'(issue_valid), 32'd0);
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("flush_ready", 32'(enq_ready), 32'd1);
    applyStimulus(4'd3, OP_MULT, 4'hF, 32'h33, 32'h44, 6'd23);
    tick();
    checkOutput("post_flush_rob", 32'(issue_rob1), 32'd3);
    checkOutput("post_flush_count", 32'(count), 32'd1);
    tick();
    enq_valid = 1'b0;
    checkOutput("pre_reset_count", 32'(count), 32'd2);

    // Asynchronous reset mid-stream.
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_count", 32'(count), 32'd0);
    checkOutput("async_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("async_enq_ready", 32'(enq_ready), 32'd1);
    checkOutput("async_src1", issue_src1, 32'd0);
    checkOutput("async_rob1", 32'(issue_rob1), 32'd0);
    #3 resetn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
